tick_gen_multi: RTL

Multi-channel, runtime-programmable tick generator that replaces the single fixed-ratio program-clock divider. It sits beside the top-level state controller, runs on the system clock and emits one-cycle clock-enable ticks per channel: program tick, note-sequencer tick, display-refresh tick and so on. Each channel has its own divisor and periodic/one-shot mode, plus a global realign strobe so that page transitions restart all timing coherently.

---
 rtl/tick_gen_multi_pkg.sv | 13 +
 rtl/tick_channel.sv | 100 ++++++++++
 rtl/tick_gen_multi.sv | 51 +++++
 3 files changed

// File: rtl/tick_gen_multi_pkg.sv
// tick_gen_multi shared package: clock ratio constants
// and the per-channel tick mode.
package tick_gen_multi_pkg;

  localparam int unsigned SYS_FREQ  = 12_000_000;
  localparam int unsigned PROG_FREQ = 1_000;

  typedef enum logic {
    PERIODIC = 1'b0,
    ONESHOT  = 1'b1
  } TickMode;

endpackage

// File: rtl/tick_channel.sv
// One tick channel: divisor, mode, counter, one-shot state.
// Phase register exists only with TICK_GEN_PHASE_EN.
module tick_channel
  import tick_gen_multi_pkg::*;
#(
  parameter int               CNT_W       = 24,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             restart_i,
  input  logic             we_i,
  input  logic [CNT_W-1:0] div_i,
  input  TickMode          mode_i,
  input  logic [CNT_W-1:0] phase_i,
  output logic             tick_o,
  output logic             busy_o
);

  localparam logic [CNT_W-1:0] ONE = 1;

  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wdiv, ld_phase;
  TickMode          mode_q, mode_d;
  logic             done_q, done_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;

  assign wdiv = (div_i == '0) ? ONE : div_i;

`ifdef TICK_GEN_PHASE_EN
  logic [CNT_W-1:0] phase_q;
  logic [CNT_W-1:0] wphase;

  // Clamp once at write time; div only changes on a write.
  assign wphase   = (phase_i >= wdiv) ? '0 : phase_i;
  assign ld_phase = we_i ? wphase : phase_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= '0;
    end else if (we_i) begin
      phase_q <= wphase;
    end
  end
`else
  logic unused_phase;
  assign unused_phase = ^phase_i;
  assign ld_phase     = '0;
`endif

  always_comb begin
    div_d  = div_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    tick_d = 1'b0;
    if (we_i) begin
      div_d  = wdiv;
      mode_d = mode_i;
    end
    if (we_i || restart_i || !en_i) begin
      cnt_d  = ld_phase;
      done_d = 1'b0;
    end else if (!done_q) begin
      if (cnt_q == div_q - ONE) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        done_d = (mode_q == ONESHOT);
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
    busy_d = (mode_d == ONESHOT) && en_i && !done_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q  <= DEFAULT_DIV;
      mode_q <= PERIODIC;
      cnt_q  <= '0;
      done_q <= 1'b0;
      tick_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      tick_q <= tick_d;
      busy_q <= busy_d;
    end
  end

  assign tick_o = tick_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator top.
// Optional phase feature: define TICK_GEN_PHASE_EN.
module tick_gen_multi
  import tick_gen_multi_pkg::*;
#(
  parameter int               N_CH        = 4,
  parameter int               CNT_W       = 24,
  parameter logic [CNT_W-1:0] DEFAULT_DIV =
    CNT_W'(SYS_FREQ / PROG_FREQ),
  localparam int              CH_W        =
    (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             sys_rst_n,
  input  logic [N_CH-1:0]  ch_en,
  input  logic             sync_restart,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_mode,
  input  logic [CNT_W-1:0] cfg_phase,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  busy
);

  TickMode mode_w;
  assign mode_w = TickMode'(cfg_mode);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic we;
    // Out-of-range indices match no channel and are dropped.
    assign we = cfg_we && (cfg_ch == CH_W'(i));

    tick_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_i     (clk),
      .rst_ni    (sys_rst_n),
      .en_i      (ch_en[i]),
      .restart_i (sync_restart),
      .we_i      (we),
      .div_i     (cfg_div),
      .mode_i    (mode_w),
      .phase_i   (cfg_phase),
      .tick_o    (tick[i]),
      .busy_o    (busy[i])
    );
  end

endmodule
